shift_button_scanner: RTL and testbench



---
 rtl/shift_button_scanner.sv | 145 ++++++++++++++
 tb/tb_shift_button_scanner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_button_scanner.sv
// Scans the display board's PISO button shift register, debounces each bit and
// reports a stable button vector with press events. Define SHIFT_SCAN_RELEASE_EN for release events.
//
// state      | meaning
// S_IDLE     | waiting for interval expiry, scan_req or pending request
// S_LOAD     | SHIFT_LOAD low, register captures the buttons in parallel
// S_SHIFT_LO | SHIFT_CLKIN low, serial bit sampled on the last cycle
// S_SHIFT_HI | SHIFT_CLKIN high, register advances to the next bit
// S_DONE     | debounce update, results presented on the following cycle
module shift_button_scanner #(
  parameter int NBITS         = 16,
  parameter int CLKDIV        = 25,
  parameter int SCAN_INTERVAL = 50000,
  parameter int DEBOUNCE      = 4
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             SHIFT_OUT,
  input  logic             scan_req,
  output logic             SHIFT_LOAD,
  output logic             SHIFT_CLKIN,
  output logic [NBITS-1:0] buttons,
  output logic [NBITS-1:0] pressed,
`ifdef SHIFT_SCAN_RELEASE_EN
  output logic [NBITS-1:0] released,
`endif
  output logic             scan_done
);

  localparam int IW  = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
  localparam int DW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BW  = $clog2(NBITS + 1);
  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    int_cnt;
  logic [DW-1:0]    div_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             pending;
  logic [1:0]       sync_q;
  logic [NBITS-1:0] sbuf;
  logic [NBITS:0]   sbuf_shift;
  logic [DBW-1:0]   db_cnt [NBITS];
  logic             load_d, clkin_d;
  logic             div_last, int_last, bits_done;

  assign div_last   = (div_cnt == DW'(CLKDIV - 1));
  assign int_last   = (int_cnt == IW'(SCAN_INTERVAL - 1));
  assign bits_done  = (bit_cnt == BW'(NBITS));
  assign sbuf_shift = {sbuf, ~sync_q[1]};

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (int_last || scan_req || pending) state_nx = S_LOAD;
      S_LOAD:     if (div_last) state_nx = S_SHIFT_LO;
      S_SHIFT_LO: if (div_last) state_nx = S_SHIFT_HI;
      S_SHIFT_HI: if (div_last) state_nx = bits_done ? S_DONE : S_SHIFT_LO;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up with the state.
  always_comb begin
    load_d  = (state_nx != S_LOAD);
    clkin_d = (state_nx == S_SHIFT_HI);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      SHIFT_LOAD  <= 1'b1;
      SHIFT_CLKIN <= 1'b0;
      sync_q      <= 2'b11;
    end else begin
      SHIFT_LOAD  <= load_d;
      SHIFT_CLKIN <= clkin_d;
      sync_q      <= {sync_q[0], SHIFT_OUT};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      int_cnt <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
      sbuf    <= '0;
    end else begin
      int_cnt <= (state == S_IDLE && state_nx == S_IDLE) ? int_cnt + 1'b1 : '0;
      div_cnt <= (state_nx == state && state != S_IDLE && state != S_DONE) ? div_cnt + 1'b1 : '0;
      if (state == S_IDLE && state_nx != S_IDLE) pending <= 1'b0;
      else if (scan_req && state != S_IDLE)      pending <= 1'b1;
      if (state == S_LOAD) bit_cnt <= '0;
      else if (state == S_SHIFT_LO && div_last) begin
        bit_cnt <= bit_cnt + 1'b1;
        sbuf    <= sbuf_shift[NBITS-1:0];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      buttons   <= '0;
      pressed   <= '0;
      scan_done <= 1'b0;
`ifdef SHIFT_SCAN_RELEASE_EN
      released  <= '0;
`endif
      for (int i = 0; i < NBITS; i++) db_cnt[i] <= '0;
    end else begin
      pressed   <= '0;
      scan_done <= (state == S_DONE);
`ifdef SHIFT_SCAN_RELEASE_EN
      released  <= '0;
`endif
      if (state == S_DONE) begin
        for (int i = 0; i < NBITS; i++) begin
          if (sbuf[i] == buttons[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
            buttons[i]  <= sbuf[i];
            pressed[i]  <= sbuf[i];
`ifdef SHIFT_SCAN_RELEASE_EN
            released[i] <= ~sbuf[i];
`endif
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_button_scanner.sv
// Scoreboard bench for shift_button_scanner with a behavioural 4-bit PISO register.
// Build with SHIFT_SCAN_RELEASE_EN defined to also check the release events.
module tb_shift_button_scanner;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic       scan_req = 1'b0;
  logic       SHIFT_OUT;
  logic       SHIFT_LOAD, SHIFT_CLKIN, scan_done;
  logic [3:0] buttons, pressed;
`ifdef SHIFT_SCAN_RELEASE_EN
  logic [3:0] released;
`endif

  shift_button_scanner #(
    .NBITS(4), .CLKDIV(2), .SCAN_INTERVAL(10), .DEBOUNCE(2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .SHIFT_OUT  (SHIFT_OUT),
    .scan_req   (scan_req),
    .SHIFT_LOAD (SHIFT_LOAD),
    .SHIFT_CLKIN(SHIFT_CLKIN),
    .buttons    (buttons),
    .pressed    (pressed),
`ifdef SHIFT_SCAN_RELEASE_EN
    .released   (released),
`endif
    .scan_done  (scan_done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // PISO model: parallel inputs are active-low, MSB leaves first.
  logic [3:0] piso_par = 4'b1111;
  logic [3:0] piso_q   = 4'b1111;
  always @(posedge SHIFT_CLKIN or negedge SHIFT_LOAD) begin
    if (!SHIFT_LOAD) piso_q <= piso_par;
    else             piso_q <= {piso_q[2:0], 1'b1};
  end
  assign SHIFT_OUT = piso_q[3];

  typedef struct {
    logic [3:0] b;
    logic [3:0] p;
    logic [3:0] r;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] b, input logic [3:0] p, input logic [3:0] r);
    exp_t e;
    e.b = b; e.p = p; e.r = r;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (scan_done !== 1'b1 && n < 300);
    check("scan_done_seen", 32'(scan_done), 32'd1);
  endtask

  task automatic run_scan(input logic [3:0] par, input logic [3:0] b,
                          input logic [3:0] p, input logic [3:0] r);
    int n;
    piso_par = par;
    push(b, p, r);
    wait_done(n);
  endtask

  // Monitor: pops an expectation on every scan_done, otherwise event pulses must be low.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (scan_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_scan_done: got scan_done=1 with no scan expected");
        end else begin
          e = sb_q.pop_front();
          check("buttons", 32'(buttons), 32'(e.b));
          check("pressed", 32'(pressed), 32'(e.p));
`ifdef SHIFT_SCAN_RELEASE_EN
          check("released", 32'(released), 32'(e.r));
`endif
        end
      end else begin
        check("pressed_quiet", 32'(pressed), 32'd0);
`ifdef SHIFT_SCAN_RELEASE_EN
        check("released_quiet", 32'(released), 32'd0);
`endif
      end
    end
  end

  initial begin
    int n;
    int fall_at;

    piso_par = 4'b1011;
    RESET_N  = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_shift_load", 32'(SHIFT_LOAD), 32'd1);
    check("rst_shift_clkin", 32'(SHIFT_CLKIN), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_pressed", 32'(pressed), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    RESET_N = 1'b1;

    // First scan after reset: timing of load and completion.
    push(4'b0000, 4'b0000, 4'b0000);
    fall_at = -1;
    for (int i = 1; i <= 40 && fall_at < 0; i++) begin
      @(negedge CLOCK_50);
      if (!SHIFT_LOAD) fall_at = i;
    end
    check("load_fall_cycle", 32'(fall_at), 32'd10);
    wait_done(n);
    check("scan_length", 32'(n), 32'd19);

    // Press debounce, then release back to idle.
    run_scan(4'b1011, 4'b0100, 4'b0100, 4'b0000);
    run_scan(4'b1011, 4'b0100, 4'b0000, 4'b0000);
    run_scan(4'b1111, 4'b0100, 4'b0000, 4'b0000);
    run_scan(4'b1111, 4'b0000, 4'b0000, 4'b0100);

    // Glitch on button 0 for a single scan.
    run_scan(4'b1110, 4'b0000, 4'b0000, 4'b0000);
    run_scan(4'b1111, 4'b0000, 4'b0000, 4'b0000);

    // scan_req in IDLE with the interval counter at 3.
    repeat (3) @(negedge CLOCK_50);
    check("load_before_req", 32'(SHIFT_LOAD), 32'd1);
    push(4'b0000, 4'b0000, 4'b0000);
    scan_req = 1'b1;
    @(negedge CLOCK_50);
    check("load_after_req", 32'(SHIFT_LOAD), 32'd0);
    scan_req = 1'b0;
    wait_done(n);

    // scan_req during SHIFT_HI: the following scan starts without an idle interval.
    push(4'b0000, 4'b0000, 4'b0000);
    push(4'b0000, 4'b0000, 4'b0000);
    n = 0;
    while (SHIFT_CLKIN !== 1'b1 && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("reached_shift_hi", 32'(SHIFT_CLKIN), 32'd1);
    scan_req = 1'b1;
    @(negedge CLOCK_50);
    scan_req = 1'b0;
    wait_done(n);
    check("load_at_done", 32'(SHIFT_LOAD), 32'd1);
    @(negedge CLOCK_50);
    check("load_after_pending", 32'(SHIFT_LOAD), 32'd0);
    wait_done(n);

    // Reset during the third SHIFT_LO with button 2 held.
    run_scan(4'b1011, 4'b0000, 4'b0000, 4'b0000);
    run_scan(4'b1011, 4'b0100, 4'b0100, 4'b0000);
    n = 0;
    while (SHIFT_LOAD !== 1'b0 && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("load_seen", 32'(SHIFT_LOAD), 32'd0);
    repeat (10) @(negedge CLOCK_50);
    check("in_shift_lo3", 32'({SHIFT_LOAD, SHIFT_CLKIN}), 32'b10);
    check("buttons_before_reset", 32'(buttons), 32'b0100);
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    check("midrst_buttons", 32'(buttons), 32'd0);
    check("midrst_shift_load", 32'(SHIFT_LOAD), 32'd1);
    check("midrst_shift_clkin", 32'(SHIFT_CLKIN), 32'd0);
    check("midrst_scan_done", 32'(scan_done), 32'd0);
    RESET_N = 1'b1;
    run_scan(4'b1111, 4'b0000, 4'b0000, 4'b0000);

    repeat (3) @(negedge CLOCK_50);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
